// File: rtl/umi_merge_pkg.sv
// rtl/umi_merge_pkg.sv - shared constants and types for the UMI merge arbiter
//
// Purpose: holds the EOM bit position inside the UMI command word and the
// arbitration state type used by umi_merge_arbiter.
// Ports: none (package).
package umi_merge_pkg;

  localparam int EOM_BIT = 22;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_RESP = 2'd1,
    LOCK_REQ  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/umi_arb_skid.sv
// rtl/umi_arb_skid.sv - 2-entry valid/ready skid buffer for the merged UMI beat
//
// Purpose: decouples the downstream ready from the arbiter. Both the output
// payload and the upstream ready come straight from registers.
// Ports:
//   clk, nreset                        clock, asynchronous active-low reset
//   i_valid / o_ready                  upstream handshake
//   i_cmd, i_dstaddr, i_srcaddr, i_data  upstream payload
//   o_valid / i_ready                  downstream handshake
//   o_cmd, o_dstaddr, o_srcaddr, o_data  downstream payload
module umi_arb_skid #(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [CW-1:0] i_cmd,
  input  logic [AW-1:0] i_dstaddr,
  input  logic [AW-1:0] i_srcaddr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_cmd,
  output logic [AW-1:0] o_dstaddr,
  output logic [AW-1:0] o_srcaddr,
  output logic [DW-1:0] o_data
);

  localparam int PW = CW + 2 * AW + DW;

  logic [PW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          r_space;

  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_count_nxt;

  assign o_valid = (r_count != 2'd0);
  assign o_ready = r_space;
  assign w_push  = i_valid & r_space;
  assign w_pop   = o_valid & i_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // r_space resets low so nothing is accepted while reset is asserted, and is
  // recomputed from the next occupancy so ready drops on the same edge the
  // buffer fills.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_space  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_space <= (w_count_nxt != 2'd2);
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd, i_dstaddr, i_srcaddr, i_data};
    end
  end

  assign {o_cmd, o_dstaddr, o_srcaddr, o_data} = r_mem[r_rd_ptr];

endmodule

// File: rtl/umi_merge_arbiter.sv
// rtl/umi_merge_arbiter.sv - merges a UMI response and request stream onto one output
//
// Purpose: responses win by default; a starvation guard hands the port to a
// waiting request after STARVE_LIMIT response messages. A grant is held from
// the first beat of a message until its EOM beat (cmd[22]).
// Ports:
//   clk, nreset                 clock, asynchronous active-low reset
//   umi_resp_in_*               response input (valid/cmd/dstaddr/srcaddr/data in, ready out)
//   umi_req_in_*                request input  (valid/cmd/dstaddr/srcaddr/data in, ready out)
//   umi_out_*                   merged output  (valid/cmd/dstaddr/srcaddr/data out, ready in)
//   stat_resp_msgs, stat_req_msgs  saturating message counters, only with UMI_MERGE_STATS_EN
// Build option: define UMI_MERGE_STATS_EN to add the message counters.
module umi_merge_arbiter
  import umi_merge_pkg::*;
#(
  parameter int DW           = 256,
  parameter int AW           = 64,
  parameter int CW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_resp_in_valid,
  input  logic [CW-1:0] umi_resp_in_cmd,
  input  logic [AW-1:0] umi_resp_in_dstaddr,
  input  logic [AW-1:0] umi_resp_in_srcaddr,
  input  logic [DW-1:0] umi_resp_in_data,
  output logic          umi_resp_in_ready,
  input  logic          umi_req_in_valid,
  input  logic [CW-1:0] umi_req_in_cmd,
  input  logic [AW-1:0] umi_req_in_dstaddr,
  input  logic [AW-1:0] umi_req_in_srcaddr,
  input  logic [DW-1:0] umi_req_in_data,
  output logic          umi_req_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready
`ifdef UMI_MERGE_STATS_EN
  ,
  output logic [31:0]   stat_resp_msgs,
  output logic [31:0]   stat_req_msgs
`endif
);

  localparam int SCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic [SCW-1:0] r_starve_cnt;

  logic           w_space;
  logic           w_starved;
  logic           w_pick_req;
  logic           w_grant_resp;
  logic           w_grant_req;
  logic           w_resp_acc;
  logic           w_req_acc;
  logic           w_resp_eom;
  logic           w_req_eom;
  logic           w_push_valid;
  logic [CW-1:0]  w_push_cmd;
  logic [AW-1:0]  w_push_dstaddr;
  logic [AW-1:0]  w_push_srcaddr;
  logic [DW-1:0]  w_push_data;

  assign w_starved  = (STARVE_LIMIT != 0) && (r_starve_cnt >= SCW'(STARVE_LIMIT));
  // In IDLE a request takes the port only when no response competes or the
  // responses have already had their quota of consecutive messages.
  assign w_pick_req = umi_req_in_valid & (~umi_resp_in_valid | w_starved);

  always_comb begin
    w_grant_resp = 1'b0;
    w_grant_req  = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_resp = umi_resp_in_valid & ~w_pick_req;
        w_grant_req  = w_pick_req;
      end
      LOCK_RESP: w_grant_resp = 1'b1;
      LOCK_REQ:  w_grant_req  = 1'b1;
      default: begin
        w_grant_resp = 1'b0;
        w_grant_req  = 1'b0;
      end
    endcase
  end

  assign umi_resp_in_ready = w_grant_resp & w_space;
  assign umi_req_in_ready  = w_grant_req & w_space;
  assign w_resp_acc        = umi_resp_in_valid & umi_resp_in_ready;
  assign w_req_acc         = umi_req_in_valid & umi_req_in_ready;
  assign w_resp_eom        = umi_resp_in_cmd[EOM_BIT];
  assign w_req_eom         = umi_req_in_cmd[EOM_BIT];

  always_comb begin
    w_state_nxt = r_state;
    if (w_resp_acc) begin
      w_state_nxt = w_resp_eom ? IDLE : LOCK_RESP;
    end else if (w_req_acc) begin
      w_state_nxt = w_req_eom ? IDLE : LOCK_REQ;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_acc && w_req_eom) begin
        r_starve_cnt <= '0;
      end else if (w_resp_acc && w_resp_eom && umi_req_in_valid &&
                   (r_starve_cnt < SCW'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + SCW'(1);
      end
    end
  end

  assign w_push_valid   = (w_grant_resp & umi_resp_in_valid) | (w_grant_req & umi_req_in_valid);
  assign w_push_cmd     = w_grant_req ? umi_req_in_cmd     : umi_resp_in_cmd;
  assign w_push_dstaddr = w_grant_req ? umi_req_in_dstaddr : umi_resp_in_dstaddr;
  assign w_push_srcaddr = w_grant_req ? umi_req_in_srcaddr : umi_resp_in_srcaddr;
  assign w_push_data    = w_grant_req ? umi_req_in_data    : umi_resp_in_data;

  umi_arb_skid #(
    .DW (DW),
    .AW (AW),
    .CW (CW)
  ) u_skid (
    .clk       (clk),
    .nreset    (nreset),
    .i_valid   (w_push_valid),
    .o_ready   (w_space),
    .i_cmd     (w_push_cmd),
    .i_dstaddr (w_push_dstaddr),
    .i_srcaddr (w_push_srcaddr),
    .i_data    (w_push_data),
    .o_valid   (umi_out_valid),
    .i_ready   (umi_out_ready),
    .o_cmd     (umi_out_cmd),
    .o_dstaddr (umi_out_dstaddr),
    .o_srcaddr (umi_out_srcaddr),
    .o_data    (umi_out_data)
  );

`ifdef UMI_MERGE_STATS_EN
  logic [31:0] r_stat_resp;
  logic [31:0] r_stat_req;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_stat_resp <= '0;
      r_stat_req  <= '0;
    end else begin
      if (w_resp_acc && w_resp_eom && (r_stat_resp != 32'hFFFF_FFFF)) begin
        r_stat_resp <= r_stat_resp + 32'd1;
      end
      if (w_req_acc && w_req_eom && (r_stat_req != 32'hFFFF_FFFF)) begin
        r_stat_req <= r_stat_req + 32'd1;
      end
    end
  end

  assign stat_resp_msgs = r_stat_resp;
  assign stat_req_msgs  = r_stat_req;
`endif

endmodule
